cpu_addr_seq: RTL

- Addressing-mode sequencer for the 6502 core; replaces the single-mode controller FSM.
- Given an opcode at decode (T0), it runs every group-01 addressing mode (bbb field). It fetches operand and pointer bytes over the CPU memory bus, honouring RDY stalls.
- It computes the effective address with X/Y indexing, zero-page wrap and page-cross fix-up.
- The core's ALU/register datapath consumes ea and data on a one-cycle done pulse.

---
 rtl/cpu_addr_seq_if.sv | 29 ++
 rtl/cpu_addr_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_addr_seq_if.sv
// Signal bundle between the 6502 decode/datapath (master) and the addressing-mode sequencer (slave).
interface cpu_addr_seq_if;
   logic        start;
   logic [7:0]  opcode;
   logic        is_store;
   logic [15:0] pc_in;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [7:0]  d_in;
   logic        rdy;
   logic [15:0] addr;
   logic        rd;
   logic        busy;
   logic        done;
   logic [15:0] ea;
   logic [7:0]  data;
   logic [15:0] pc_next;
   logic        penalty;

   modport master (
      output start, opcode, is_store, pc_in, x, y, d_in, rdy,
      input  addr, rd, busy, done, ea, data, pc_next, penalty
   );

   modport slave (
      input  start, opcode, is_store, pc_in, x, y, d_in, rdy,
      output addr, rd, busy, done, ea, data, pc_next, penalty
   );
endinterface

// File: rtl/cpu_addr_seq.sv
// Group-01 addressing-mode sequencer: one bus read per state, done pulses the cycle after the last read.
// rdy=0 freezes the current read (state, addr, rd); start is only accepted in IDLE.
module cpu_addr_seq #(
   parameter bit ZP_WRAP      = 1'b1,
   parameter bit PAGE_PENALTY = 1'b1,
   parameter bit STORE_FIXUP  = 1'b1
) (
   input logic           clk_i,
   input logic           rst_ni,
   cpu_addr_seq_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_OP1, S_OP2, S_IDX, S_PTR_L, S_PTR_H, S_FIX, S_DONE
   } state_t;

   localparam logic [2:0] M_IZX = 3'b000, M_ZP  = 3'b001, M_IMM = 3'b010, M_ABS = 3'b011;
   localparam logic [2:0] M_IZY = 3'b100, M_ZPX = 3'b101, M_ABY = 3'b110, M_ABX = 3'b111;

   function automatic logic [15:0] zp(input logic [15:0] v);
      return ZP_WRAP ? {8'h00, v[7:0]} : v;
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  bbb_q, bbb_d;
   logic        store_q, store_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  op_q, op_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] ptr_q, ptr_d;
   logic [15:0] ea_q, ea_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] pcn_q, pcn_d;
   logic        pen_q, pen_d;

   logic        fin, fin_pen;
   logic [15:0] fin_ea;
   logic [7:0]  fin_data;

   logic [7:0]  idx;
   logic [8:0]  sum_op, sum_lo;
   logic        fix_op, fix_lo;
   logic [15:0] zpx_addr;
   logic        unused_opcode_bits;

   // Only abs,X uses X for the indexed-base add; abs,Y and (zp),Y both use Y.
   assign idx      = (bbb_q == M_ABX) ? bus.x : bus.y;
   assign sum_op   = {1'b0, op_q} + {1'b0, idx};
   assign sum_lo   = {1'b0, lo_q} + {1'b0, idx};
   assign fix_op   = (PAGE_PENALTY && sum_op[8]) || (STORE_FIXUP && store_q);
   assign fix_lo   = (PAGE_PENALTY && sum_lo[8]) || (STORE_FIXUP && store_q);
   assign zpx_addr = zp({8'h00, op_q} + {8'h00, bus.x});
   assign unused_opcode_bits = ^{bus.opcode[7:5], bus.opcode[1:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         bbb_q   <= '0;
         store_q <= 1'b0;
         pc_q    <= '0;
         op_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         ptr_q   <= '0;
         ea_q    <= '0;
         data_q  <= '0;
         pcn_q   <= '0;
         pen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bbb_q   <= bbb_d;
         store_q <= store_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         ptr_q   <= ptr_d;
         ea_q    <= ea_d;
         data_q  <= data_d;
         pcn_q   <= pcn_d;
         pen_q   <= pen_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bbb_d    = bbb_q;
      store_d  = store_q;
      pc_d     = pc_q;
      op_d     = op_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      ptr_d    = ptr_q;
      ea_d     = ea_q;
      data_d   = data_q;
      pcn_d    = pcn_q;
      pen_d    = pen_q;
      fin      = 1'b0;
      fin_ea   = '0;
      fin_data = '0;
      fin_pen  = 1'b0;
      case (state_q)
         S_IDLE: if (bus.start) begin
            bbb_d   = bus.opcode[4:2];
            store_d = bus.is_store;
            pc_d    = bus.pc_in;
            state_d = S_OP1;
         end
         S_OP1: if (bus.rdy) begin
            op_d  = bus.d_in;
            ptr_d = {8'h00, bus.d_in};
            case (bbb_q)
               M_IMM:        begin fin = 1'b1; fin_ea = pc_q; fin_data = bus.d_in; end
               M_ZP:         begin fin = 1'b1; fin_ea = {8'h00, bus.d_in}; end
               M_ZPX, M_IZX: state_d = S_IDX;
               M_IZY:        state_d = S_PTR_L;
               default:      state_d = S_OP2;
            endcase
         end
         S_OP2: if (bus.rdy) begin
            lo_d = op_q;
            hi_d = bus.d_in;
            if (bbb_q == M_ABS) begin
               fin = 1'b1; fin_ea = {bus.d_in, op_q};
            end else if (fix_op) begin
               state_d = S_FIX;
            end else begin
               fin = 1'b1; fin_ea = {bus.d_in, op_q} + {8'h00, idx};
            end
         end
         S_IDX: if (bus.rdy) begin
            if (bbb_q == M_ZPX) begin
               fin = 1'b1; fin_ea = zpx_addr;
            end else begin
               ptr_d   = zpx_addr;
               state_d = S_PTR_L;
            end
         end
         S_PTR_L: if (bus.rdy) begin
            lo_d    = bus.d_in;
            state_d = S_PTR_H;
         end
         S_PTR_H: if (bus.rdy) begin
            hi_d = bus.d_in;
            if (bbb_q == M_IZX) begin
               fin = 1'b1; fin_ea = {bus.d_in, lo_q};
            end else if (fix_lo) begin
               state_d = S_FIX;
            end else begin
               fin = 1'b1; fin_ea = {bus.d_in, lo_q} + {8'h00, idx};
            end
         end
         S_FIX: if (bus.rdy) begin
            fin = 1'b1; fin_pen = 1'b1; fin_ea = {hi_q, lo_q} + {8'h00, idx};
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (fin) begin
         state_d = S_DONE;
         ea_d    = fin_ea;
         data_d  = fin_data;
         pen_d   = fin_pen;
         pcn_d   = pc_q + ((bbb_q == M_ABS || bbb_q == M_ABX || bbb_q == M_ABY) ? 16'd2 : 16'd1);
      end
   end

   always_comb begin
      bus.addr = '0;
      bus.rd   = 1'b0;
      bus.busy = (state_q != S_IDLE);
      bus.done = (state_q == S_DONE);
      case (state_q)
         S_OP1:   begin bus.addr = pc_q;                  bus.rd = 1'b1; end
         S_OP2:   begin bus.addr = pc_q + 16'd1;          bus.rd = 1'b1; end
         S_IDX:   begin bus.addr = {8'h00, op_q};         bus.rd = 1'b1; end
         S_PTR_L: begin bus.addr = ptr_q;                 bus.rd = 1'b1; end
         S_PTR_H: begin bus.addr = zp(ptr_q + 16'd1);     bus.rd = 1'b1; end
         S_FIX:   begin bus.addr = {hi_q, sum_lo[7:0]};   bus.rd = 1'b1; end
         default: ;
      endcase
   end

   assign bus.ea      = ea_q;
   assign bus.data    = data_q;
   assign bus.pc_next = pcn_q;
   assign bus.penalty = pen_q;
endmodule
